// File: rtl/shift_operand_stage.sv
// Two-entry in-order operand buffer (head + skid) between decode and the shift unit.
// Held rs1 values are refreshed from the writeback bypass until the entry is consumed.
module shift_operand_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [4:0]      in_shamt,
    input  logic            in_funct3_2,
    input  logic            in_funct7_5,
    input  logic [AW-1:0]   in_rd,
    input  logic            flush,
    input  logic            fwd_en,
    input  logic [AW-1:0]   fwd_addr,
    input  logic [XLEN-1:0] fwd_data,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] Rs1,
    output logic [4:0]      Rs2,
    output logic            funct3_2,
    output logic            funct7_5,
    output logic            En,
    output logic [AW-1:0]   out_rd,
    output logic            err_illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic [4:0]      shamt;
        logic            f3;
        logic            f7;
        logic [AW-1:0]   rd;
    } entry_t;

    state_t state, state_n;
    entry_t head, skid, head_n, skid_n;
    entry_t new_e, head_fw, skid_fw;
    logic   ready_q;
    logic   push, push_st, pop, illegal;

    function automatic logic fwd_hit(input logic en, input logic [AW-1:0] fa,
                                     input logic [AW-1:0] a);
        return en && (fa == a) && (a != '0);
    endfunction

    // ready_q keeps in_ready low during reset and purely registered afterwards
    assign in_ready  = ready_q && (state != TWO);
    assign out_valid = (state != EMPTY);
    assign illegal   = in_funct7_5 && !in_funct3_2;
    assign push      = in_valid && in_ready && !flush;
    assign push_st   = push && !illegal;
    assign pop       = out_valid && out_ready;

    always_comb begin
        new_e       = '0;
        new_e.addr  = in_rs1_addr;
        new_e.data  = fwd_hit(fwd_en, fwd_addr, in_rs1_addr) ? fwd_data : in_rs1_data;
        new_e.shamt = in_shamt;
        new_e.f3    = in_funct3_2;
        new_e.f7    = in_funct7_5;
        new_e.rd    = in_rd;
        head_fw     = head;
        skid_fw     = skid;
        if (fwd_hit(fwd_en, fwd_addr, head.addr)) head_fw.data = fwd_data;
        if (fwd_hit(fwd_en, fwd_addr, skid.addr)) skid_fw.data = fwd_data;
    end

    always_comb begin
        state_n = state;
        head_n  = head;
        skid_n  = skid;
        case (state)
            EMPTY: begin
                if (push_st) begin
                    head_n  = new_e;
                    state_n = ONE;
                end
            end
            ONE: begin
                if (pop && push_st) begin
                    head_n = new_e;
                end else if (pop) begin
                    state_n = EMPTY;
                end else if (push_st) begin
                    head_n  = head_fw;
                    skid_n  = new_e;
                    state_n = TWO;
                end else begin
                    head_n = head_fw;
                end
            end
            TWO: begin
                if (pop) begin
                    head_n  = skid_fw;
                    state_n = ONE;
                end else begin
                    head_n = head_fw;
                    skid_n = skid_fw;
                end
            end
            default: state_n = EMPTY;
        endcase
        if (flush) state_n = EMPTY;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            head        <= '0;
            skid        <= '0;
            ready_q     <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            state   <= state_n;
            head    <= head_n;
            skid    <= skid_n;
            ready_q <= 1'b1;
            if (push && illegal) err_illegal <= 1'b1;
        end
    end

    always_comb begin
        Rs1      = out_valid ? head_fw.data : '0;
        Rs2      = out_valid ? head.shamt : '0;
        funct3_2 = out_valid && head.f3;
        funct7_5 = out_valid && head.f7;
        out_rd   = out_valid ? head.rd : '0;
        En       = out_valid;
    end

endmodule

// File: tb/tb_shift_operand_stage.sv
// Bench for shift_operand_stage: directed scenarios then random traffic, all checked
// against a queue-based model of the operand buffer.
module tb_shift_operand_stage;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1_addr;
    logic [31:0] in_rs1_data;
    logic [4:0]  in_shamt;
    logic        in_funct3_2, in_funct7_5;
    logic [4:0]  in_rd;
    logic        flush, fwd_en;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic        out_ready, out_valid;
    logic [31:0] Rs1;
    logic [4:0]  Rs2;
    logic        funct3_2, funct7_5, En;
    logic [4:0]  out_rd;
    logic        err_illegal;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic        f3;
        logic        f7;
        logic [4:0]  rd;
    } op_t;

    op_t  mq[$];
    logic m_alive = 1'b0;
    logic m_err   = 1'b0;

    shift_operand_stage #(.XLEN(32), .AW(5)) dut (
        .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs1_data(in_rs1_data), .in_shamt(in_shamt),
        .in_funct3_2(in_funct3_2), .in_funct7_5(in_funct7_5), .in_rd(in_rd),
        .flush(flush), .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_ready(out_ready), .out_valid(out_valid), .Rs1(Rs1), .Rs2(Rs2),
        .funct3_2(funct3_2), .funct7_5(funct7_5), .En(En), .out_rd(out_rd),
        .err_illegal(err_illegal)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic bypass(input logic [4:0] a);
        return fwd_en && fwd_addr == a && a != 5'd0;
    endfunction

    task automatic checkAll();
        logic        v;
        logic [31:0] e_rs1;
        v     = mq.size() > 0;
        e_rs1 = !v ? 32'd0 : (bypass(mq[0].addr) ? fwd_data : mq[0].data);
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, m_alive && mq.size() < 2});
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, v});
        checkOutput("En", {31'd0, En}, {31'd0, v});
        checkOutput("Rs1", Rs1, e_rs1);
        checkOutput("Rs2", {27'd0, Rs2}, v ? {27'd0, mq[0].shamt} : 32'd0);
        checkOutput("funct3_2", {31'd0, funct3_2}, v ? {31'd0, mq[0].f3} : 32'd0);
        checkOutput("funct7_5", {31'd0, funct7_5}, v ? {31'd0, mq[0].f7} : 32'd0);
        checkOutput("out_rd", {27'd0, out_rd}, v ? {27'd0, mq[0].rd} : 32'd0);
        checkOutput("err_illegal", {31'd0, err_illegal}, {31'd0, m_err});
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelStep();
        logic push, pop;
        op_t  n, t;
        push = in_valid && m_alive && mq.size() < 2 && !flush;
        pop  = mq.size() > 0 && out_ready;
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            for (int i = 0; i < mq.size(); i++) begin
                t = mq[i];
                if (bypass(t.addr)) t.data = fwd_data;
                mq[i] = t;
            end
            if (push) begin
                if (in_funct7_5 && !in_funct3_2) begin
                    m_err = 1'b1;
                end else begin
                    n.addr  = in_rs1_addr;
                    n.data  = bypass(in_rs1_addr) ? fwd_data : in_rs1_data;
                    n.shamt = in_shamt;
                    n.f3    = in_funct3_2;
                    n.f7    = in_funct7_5;
                    n.rd    = in_rd;
                    mq.push_back(n);
                end
            end
        end
        m_alive = 1'b1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d,
                                 input logic [4:0] sh, input logic f3, input logic f7,
                                 input logic [4:0] rd, input logic fl, input logic fe,
                                 input logic [4:0] fa, input logic [31:0] fd, input logic ordy);
        in_valid    = v;
        in_rs1_addr = a;
        in_rs1_data = d;
        in_shamt    = sh;
        in_funct3_2 = f3;
        in_funct7_5 = f7;
        in_rd       = rd;
        flush       = fl;
        fwd_en      = fe;
        fwd_addr    = fa;
        fwd_data    = fd;
        out_ready   = ordy;
        @(negedge CLK);
        checkAll();
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, ordy);
    endtask

    // Reset asserted between edges: outputs must clear before the next edge
    task automatic resetMid();
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_alive = 1'b0;
        m_err   = 1'b0;
        checkAll();
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK);
        m_alive = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_rs1_addr = 0; in_rs1_data = 0; in_shamt = 0;
        in_funct3_2 = 0; in_funct7_5 = 0; in_rd = 0; flush = 0;
        fwd_en = 0; fwd_addr = 0; fwd_data = 0; out_ready = 0;
        resetMid();

        // single op, 1-cycle latency then empty
        applyStimulus(1, 5'd3, 32'h8000_0000, 5'd4, 1, 1, 5'd9, 0, 0, 5'd0, 32'd0, 1);
        idle(1);
        idle(1);

        // back-pressure: A,B held, C refused, then drained in order
        applyStimulus(1, 5'd1, 32'h0000_000A, 5'd1, 0, 0, 5'd11, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(1, 5'd2, 32'h0000_000B, 5'd2, 1, 0, 5'd12, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(1, 5'd4, 32'h0000_000C, 5'd3, 1, 1, 5'd13, 0, 0, 5'd0, 32'd0, 0);
        idle(1);
        idle(1);
        idle(1);

        // bypass into a held head, and address 0 never forwarded
        applyStimulus(1, 5'd7, 32'h1, 5'd5, 0, 0, 5'd7, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(0, 5'd0, 32'h0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd7, 32'hDEAD_BEEF, 0);
        idle(0);
        applyStimulus(1, 5'd0, 32'h1, 5'd6, 1, 0, 5'd8, 0, 0, 5'd0, 32'd0, 1);
        applyStimulus(0, 5'd0, 32'h0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd0, 32'hDEAD_BEEF, 0);
        idle(0);
        idle(1);

        // flush in TWO overrides push and pop
        applyStimulus(1, 5'd5, 32'h55, 5'd1, 0, 0, 5'd1, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(1, 5'd6, 32'h66, 5'd2, 0, 0, 5'd2, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(1, 5'd9, 32'h99, 5'd3, 1, 0, 5'd3, 1, 0, 5'd0, 32'd0, 1);
        idle(1);

        // illegal encoding: swallowed, sticky error survives flush
        applyStimulus(1, 5'd3, 32'h33, 5'd1, 0, 1, 5'd4, 0, 0, 5'd0, 32'd0, 1);
        idle(1);
        applyStimulus(0, 5'd0, 32'h0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd0, 32'd0, 1);
        idle(1);

        // async reset while holding two entries
        applyStimulus(1, 5'd5, 32'h55, 5'd1, 0, 0, 5'd1, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(1, 5'd6, 32'h66, 5'd2, 0, 0, 5'd2, 0, 0, 5'd0, 32'd0, 0);
        resetMid();
        idle(1);

        for (int i = 0; i < 400; i++) begin
            logic f3, f7;
            f3 = 1'($urandom_range(0, 1));
            f7 = ($urandom_range(0, 31) == 0) ? 1'b1 : (f3 ? 1'($urandom_range(0, 1)) : 1'b0);
            applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom), f3, f7, 5'($urandom),
                          $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
            if (i % 137 == 136) resetMid();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
